mac_operand_sequencer: RTL and testbench
========================================

// Module: mac_operand_sequencer
// PURPOSE
//  Upstream feeder and controller for the MAC stage. Accepts (A,B) operand pairs on a valid/ready
//  stream and buffers them in an internal FIFO. Drives the MAC's En/Ain/Bin one pair per cycle.
//  After VEC_LEN pairs it captures Cout as a dot-product result, clears the MAC, and presents the
//  result on a valid/ready output.
// PARAMETERS
//  DATA_WIDTH  8  operand width; MAC accumulator and result are 3*DATA_WIDTH
//  VEC_LEN     8  pairs per dot product; legal range >=1
//  FIFO_DEPTH  8  operand-pair buffer entries; power of 2, >=2
// PORTS
//  clk        in   1              system clock, all state on posedge
//  rst_n      in   1              asynchronous active-low reset
//  in_valid   in   1              operand pair valid
//  in_ready   out  1              operand pair accepted when in_valid&&in_ready; = !fifo_full
//  in_a       in   DATA_WIDTH     operand A
//  in_b       in   DATA_WIDTH     operand B
//  mac_en     out  1              MAC En; registered
//  mac_clr    out  1              MAC Clr; decoded from state CAPT
//  mac_ain    out  DATA_WIDTH     MAC Ain; registered, loaded on FIFO pop
//  mac_bin    out  DATA_WIDTH     MAC Bin; registered, loaded on FIFO pop
//  mac_cout   in   3*DATA_WIDTH   MAC Cout (registered accumulator)
//  res_valid  out  1              dot-product result valid; held until res_ready
//  res_ready  in   1              downstream accepts result
//  res_data   out  3*DATA_WIDTH   captured accumulator value
//  busy       out  1              high when state!=ACCUM, or pair count!=0, or FIFO non-empty
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - FIFO is emptied; pair counter = 0; state = ACCUM.
//   - mac_en, mac_ain, mac_bin, res_valid and res_data are all 0; mac_clr = 0.
//   - in_ready = 1 (FIFO empty). Push attempts during reset are ignored.
//   - The MAC shares rst_n, so its accumulator is also 0.
//  FIFO:
//   - Push on in_valid&&in_ready.
//   - No bypass: a pair pushed at edge N is poppable at edge N+1 at the earliest.
//   - Full: in_ready=0, so no push at full. Empty: no pop.
//   - Push and pop in the same edge are allowed when neither full nor empty; count is unchanged.
//   - Pointers wrap modulo FIFO_DEPTH.
//  FSM states: ACCUM, FLUSH, CAPT, RESULT.
//   - ACCUM: each edge with FIFO non-empty pops one pair into mac_ain/mac_bin, sets mac_en=1,
//     and increments the counter. An edge with FIFO empty sets mac_en=0.
//     On the pop that makes count==VEC_LEN, go to FLUSH and clear the counter.
//   - FLUSH (1 cycle): mac_en=1 for the last pair, so the MAC accumulates it at the end of FLUSH.
//     No pop. Next edge: mac_en<=0, go to CAPT.
//   - CAPT (1 cycle): mac_en=0, mac_clr=1, mac_cout final and stable.
//     At the edge: res_data<=mac_cout, res_valid<=1, MAC clears; go to RESULT.
//   - RESULT: hold res_valid/res_data until res_ready=1; on that edge res_valid<=0, go to ACCUM.
//     No pops in RESULT, but the FIFO keeps accepting pushes until full.
//  Invariants:
//   - mac_en and mac_clr are never 1 in the same cycle.
//   - mac_en is high exactly VEC_LEN cycles per result.
//   - mac_clr is high exactly 1 cycle per result.
//  Latency:
//   - With the FIFO pre-loaded and res_ready=1, the cycle count from the first pop edge to
//     res_valid rising is VEC_LEN+2 edges.
//   - Back-to-back vectors lose 1 cycle in RESULT.
//  Arithmetic: accumulation is in the MAC, modulo 2^(3*DATA_WIDTH). res_data is a bit-exact copy.
//  Counter: $clog2(VEC_LEN+1) bits. VEC_LEN=1 goes ACCUM->FLUSH on the first pop.
//  Reset mid-operation: all state is abandoned. Buffered and partially accumulated pairs are
//   discarded; the next vector starts from count 0 with the MAC cleared.
// TESTING (bench instantiates this block driving the real MAC, DATA_WIDTH=8, VEC_LEN=8)
//  1. Hold rst_n=0 for 5 cycles -> in_ready=1; mac_en=0; mac_clr=0; res_valid=0; res_data=0; busy=0.
//  2. Push pairs (1,1)..(8,8) back-to-back with res_ready=1.
//     -> res_data=204 (0x0000CC); mac_en high 8 consecutive cycles; one mac_clr pulse; busy falls after.
//  3. Push 16 pairs of (2,3) with res_ready=0.
//     -> first res_data=48 held; in_ready drops when the FIFO holds 8.
//     -> after res_ready=1: second result=48 (proves the clear).
//  4. Push 8 pairs of (255,255) -> res_data=520200 (0x07F008).
//  5. Push (3,5) with in_valid toggling every other cycle -> res_data=120; mac_en pulses only when the FIFO is non-empty.
//  6. Push 4 pairs of (9,9), then pulse rst_n low -> all outputs 0; then push 8 pairs of (1,2) -> res_data=16.

Source files
------------

// File: rtl/mac_operand_sequencer_if.sv
// Operand-pair input stream and dot-product result stream of the MAC sequencer.
interface mac_operand_sequencer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH-1:0]   in_a;
    logic [DATA_WIDTH-1:0]   in_b;
    logic                    res_valid;
    logic                    res_ready;
    logic [3*DATA_WIDTH-1:0] res_data;

    modport master (
        output in_valid, in_a, in_b, res_ready,
        input  in_ready, res_valid, res_data
    );

    modport slave (
        input  in_valid, in_a, in_b, res_ready,
        output in_ready, res_valid, res_data
    );
endinterface

// File: rtl/mac_operand_sequencer.sv
// Feeds buffered (A,B) pairs into an external MAC one per cycle, captures the
// accumulator after VEC_LEN pairs, clears the MAC and offers the dot product downstream.
module mac_operand_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LEN    = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mac_operand_sequencer_if.slave  bus,
    output logic                    mac_en,
    output logic                    mac_clr,
    output logic [DATA_WIDTH-1:0]   mac_ain,
    output logic [DATA_WIDTH-1:0]   mac_bin,
    input  logic [3*DATA_WIDTH-1:0] mac_cout,
    output logic                    busy
);
    localparam int CNT_W  = $clog2(VEC_LEN + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(VEC_LEN);
    localparam logic [FCNT_W-1:0] FULL_CNT = FCNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {ACCUM, FLUSH, CAPT, RESULT} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0]       fcnt_q, fcnt_d;
    logic [2*DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                    mac_en_q, mac_en_d;
    logic [DATA_WIDTH-1:0]   ain_q, ain_d;
    logic [DATA_WIDTH-1:0]   bin_q, bin_d;
    logic                    res_valid_q, res_valid_d;
    logic [3*DATA_WIDTH-1:0] res_data_q, res_data_d;
    logic                    fifo_full, fifo_empty, push, pop;

    assign fifo_full  = (fcnt_q == FULL_CNT);
    assign fifo_empty = (fcnt_q == '0);
    // Pops only happen while accumulating; an empty FIFO never pops, so a pair
    // pushed on one edge is visible to the pop logic one edge later at the earliest.
    assign push       = bus.in_valid && !fifo_full;
    assign pop        = (state_q == ACCUM) && !fifo_empty;
    assign cnt_inc    = cnt_q + 1'b1;

    assign bus.in_ready  = !fifo_full;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign mac_en        = mac_en_q;
    assign mac_ain       = ain_q;
    assign mac_bin       = bin_q;
    assign mac_clr       = (state_q == CAPT);
    assign busy          = (state_q != ACCUM) || (cnt_q != '0) || !fifo_empty;

    // Operand storage; pointers alone define occupancy, so the array needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.in_a, bus.in_b};
        end
    end

    // Next-state logic for FIFO pointers, sequencer FSM and MAC drive registers.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fcnt_d      = fcnt_q;
        mac_en_d    = mac_en_q;
        ain_d       = ain_q;
        bin_d       = bin_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + 1'b1;
            2'b01:   fcnt_d = fcnt_q - 1'b1;
            default: fcnt_d = fcnt_q;
        endcase

        case (state_q)
            ACCUM: begin
                if (pop) begin
                    ain_d    = mem_q[rd_ptr_q][2*DATA_WIDTH-1:DATA_WIDTH];
                    bin_d    = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
                    mac_en_d = 1'b1;
                    if (cnt_inc == LAST_CNT) begin
                        cnt_d   = '0;
                        state_d = FLUSH;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    mac_en_d = 1'b0;
                end
            end
            // The last pair is on the MAC inputs during this cycle.
            FLUSH: begin
                mac_en_d = 1'b0;
                state_d  = CAPT;
            end
            // Accumulator is final; mac_clr clears it on this same edge.
            CAPT: begin
                mac_en_d    = 1'b0;
                res_data_d  = mac_cout;
                res_valid_d = 1'b1;
                state_d     = RESULT;
            end
            RESULT: begin
                mac_en_d = 1'b0;
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ACCUM;
                end
            end
            default: begin
                mac_en_d = 1'b0;
                state_d  = ACCUM;
            end
        endcase
    end

    // State and output registers; reset abandons any partial vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fcnt_q      <= '0;
            mac_en_q    <= 1'b0;
            ain_q       <= '0;
            bin_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fcnt_q      <= fcnt_d;
            mac_en_q    <= mac_en_d;
            ain_q       <= ain_d;
            bin_q       <= bin_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end
endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Bench for mac_operand_sequencer driving a behavioural MAC.
module tb_mac_operand_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mac_en, mac_clr, busy;
    logic [7:0]  mac_ain, mac_bin;
    logic [23:0] mac_cout, acc;

    int errors = 0;
    int checks = 0;

    mac_operand_sequencer_if #(.DATA_WIDTH(8)) bus ();

    mac_operand_sequencer #(
        .DATA_WIDTH(8), .VEC_LEN(8), .FIFO_DEPTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .mac_en(mac_en), .mac_clr(mac_clr), .mac_ain(mac_ain), .mac_bin(mac_bin),
        .mac_cout(mac_cout), .busy(busy)
    );

    always #5 clk = ~clk;

    // MAC: registered accumulator sharing rst_n
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)       acc <= '0;
        else if (mac_clr) acc <= '0;
        else if (mac_en)  acc <= acc + 24'(mac_ain) * 24'(mac_bin);
    end
    assign mac_cout = acc;

    // activity monitor
    int en_cnt = 0, clr_cnt = 0, both_cnt = 0, run = 0, max_run = 0;
    bit track_clr = 1'b0;
    always @(negedge clk) begin
        if (mac_en)  en_cnt  <= en_cnt + 1;
        if (mac_clr) clr_cnt <= clr_cnt + 1;
        if (mac_en && mac_clr) both_cnt <= both_cnt + 1;
        if (track_clr) begin
            run <= 0; max_run <= 0;
        end else if (mac_en) begin
            run <= run + 1;
        end else begin
            if (run > max_run) max_run <= run;
            run <= 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_track();
        track_clr = 1'b1;
        @(negedge clk); @(negedge clk);
        track_clr = 1'b0;
    endtask

    task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
        bit ok = 1'b0;
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
        for (int t = 0; t < 300 && !ok; t++) begin
            ok = bus.in_ready;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL push_timeout: in_ready stayed %0d, required 1", bus.in_ready);
        end
    endtask

    task automatic wait_result(input string name, input logic [23:0] exp);
        bit seen = 1'b0;
        for (int t = 0; t < 300 && !seen; t++) begin
            if (bus.res_valid) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL %s_timeout: res_valid %0d, required 1", name, bus.res_valid);
        end else begin
            check(name, bus.res_data, exp);
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        bit          incr;
        int          gap;
        int          exp_run;
        logic [23:0] exp_res;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int en0, clr0, lat;
        vecs[0] = '{8'd1,   8'd1,   1'b1, 0, 8, 24'd204};
        vecs[1] = '{8'd255, 8'd255, 1'b0, 0, 8, 24'd520200};
        vecs[2] = '{8'd3,   8'd5,   1'b0, 1, 1, 24'd120};
        vecs[3] = '{8'd200, 8'd100, 1'b0, 0, 8, 24'd160000};
        vecs[4] = '{8'd0,   8'd77,  1'b0, 2, 1, 24'd0};

        bus.in_valid = 1'b1; bus.in_a = 8'd9; bus.in_b = 8'd9; bus.res_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_mac_en", mac_en, 0);
        check("rst_mac_clr", mac_clr, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_data", bus.res_data, 0);
        check("rst_busy", busy, 0);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        check("post_rst_busy", busy, 0);

        foreach (vecs[v]) begin
            clear_track();
            en0 = en_cnt; clr0 = clr_cnt;
            for (int i = 0; i < 8; i++) begin
                push_pair(vecs[v].incr ? vecs[v].a + 8'(i) : vecs[v].a,
                          vecs[v].incr ? vecs[v].b + 8'(i) : vecs[v].b);
                repeat (vecs[v].gap) @(negedge clk);
            end
            wait_result($sformatf("vec%0d_res", v), vecs[v].exp_res);
            check($sformatf("vec%0d_en_cycles", v), en_cnt - en0, 8);
            check($sformatf("vec%0d_clr_cycles", v), clr_cnt - clr0, 1);
            check($sformatf("vec%0d_en_run", v), max_run, vecs[v].exp_run);
            check($sformatf("vec%0d_busy", v), busy, 0);
        end

        // back-pressure: 16 pairs with the result held
        bus.res_ready = 1'b0;
        en0 = en_cnt; clr0 = clr_cnt;
        for (int i = 0; i < 16; i++) push_pair(8'd2, 8'd3);
        check("bp_in_ready_full", bus.in_ready, 0);
        repeat (3) @(negedge clk);
        check("bp_res_valid_held", bus.res_valid, 1);
        check("bp_res_data_held", bus.res_data, 48);
        check("bp_still_full", bus.in_ready, 0);
        check("bp_busy", busy, 1);
        bus.res_ready = 1'b1;
        lat = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            lat++;
            if (bus.res_valid) break;
        end
        check("bp_second_latency", lat, 11);
        wait_result("bp_second_res", 24'd48);
        check("bp_en_cycles", en_cnt - en0, 16);
        check("bp_clr_cycles", clr_cnt - clr0, 2);
        check("bp_busy_end", busy, 0);

        // reset in the middle of a vector
        for (int i = 0; i < 4; i++) push_pair(8'd9, 8'd9);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_mac_en", mac_en, 0);
        check("mid_rst_mac_ain", mac_ain, 0);
        check("mid_rst_mac_bin", mac_bin, 0);
        check("mid_rst_mac_clr", mac_clr, 0);
        check("mid_rst_res_valid", bus.res_valid, 0);
        check("mid_rst_res_data", bus.res_data, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) push_pair(8'd1, 8'd2);
        wait_result("after_rst_res", 24'd16);
        check("after_rst_busy", busy, 0);

        check("en_clr_overlap", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
